bgp_trim_sar_ctrl: RTL and testbench

// - Successive-approximation auto-trim controller for the bandgap reference's 5-bit trim word (B4..B0).
// - Drives the trim code, waits for VREF to settle, then samples an external comparator (VREF vs target)

---
 rtl/bgp_trim_sar_ctrl.sv | 129 ++++++++++++
 tb/tb_bgp_trim_sar_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bgp_trim_sar_ctrl.sv
// bgp_trim_sar_ctrl: successive-approximation auto-trim of the 5-bit bandgap trim word,
// with comparator majority voting and a manual pass-through mode.
module bgp_trim_sar_ctrl #(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         COMP_SAMPLES  = 3,
    parameter logic [4:0] RESET_CODE    = 5'd0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_manual_en,
    input  logic [4:0] i_manual_code,
    input  logic       i_comp_in,
    output logic [4:0] o_trim_code,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_result,
    output logic       o_sat_lo,
    output logic       o_sat_hi
);
    localparam int CNT_MAX = (SETTLE_CYCLES > COMP_SAMPLES) ? SETTLE_CYCLES : COMP_SAMPLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int VW      = $clog2(COMP_SAMPLES + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_code, w_code_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [VW-1:0]   r_vote, w_vote_nxt;
    logic [4:0]      r_result, w_result_nxt;
    logic            r_sat_lo, w_sat_lo_nxt;
    logic            r_sat_hi, w_sat_hi_nxt;
    logic [4:0]      r_trim, w_trim_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_vote_nxt   = r_vote;
        w_result_nxt = r_result;
        w_sat_lo_nxt = r_sat_lo;
        w_sat_hi_nxt = r_sat_hi;
        case (r_state)
            IDLE: begin
                if (i_start && !i_manual_en) begin
                    w_state_nxt = SETTLE;
                    w_code_nxt  = 5'b10000;
                    w_idx_nxt   = 3'd4;
                    w_cnt_nxt   = '0;
                    w_vote_nxt  = '0;
                end
            end
            SETTLE: begin
                w_state_nxt = (r_cnt == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
                w_cnt_nxt   = (r_cnt == CW'(SETTLE_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
            end
            SAMPLE: begin
                w_vote_nxt  = r_vote + i_comp_in;
                w_state_nxt = (r_cnt == CW'(COMP_SAMPLES - 1)) ? DECIDE : SAMPLE;
                w_cnt_nxt   = (r_cnt == CW'(COMP_SAMPLES - 1)) ? '0 : r_cnt + 1'b1;
            end
            DECIDE: begin
                // comparator high means VREF above target: the trial bit is too much
                if (r_vote > VW'(COMP_SAMPLES / 2))
                    w_code_nxt[r_idx] = 1'b0;
                if (r_idx == 3'd0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_code_nxt[r_idx - 3'd1] = 1'b1;
                    w_idx_nxt   = r_idx - 3'd1;
                    w_vote_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            DONE: begin
                w_result_nxt = r_code;
                w_sat_lo_nxt = (r_code == 5'd0);
                w_sat_hi_nxt = (r_code == 5'd31);
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt  = IDLE;
            w_result_nxt = r_result;
            w_sat_lo_nxt = r_sat_lo;
            w_sat_hi_nxt = r_sat_hi;
        end
        // outside a trim the pins show either the manual word or the last committed result
        w_trim_nxt = (w_state_nxt != IDLE) ? w_code_nxt :
                     (r_state == IDLE && i_manual_en) ? i_manual_code : w_result_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_code   <= RESET_CODE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_vote   <= '0;
            r_result <= RESET_CODE;
            r_sat_lo <= 1'b0;
            r_sat_hi <= 1'b0;
            r_trim   <= RESET_CODE;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vote   <= w_vote_nxt;
            r_result <= w_result_nxt;
            r_sat_lo <= w_sat_lo_nxt;
            r_sat_hi <= w_sat_hi_nxt;
            r_trim   <= w_trim_nxt;
        end
    end

    assign o_trim_code = r_trim;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_result    = r_result;
    assign o_sat_lo    = r_sat_lo;
    assign o_sat_hi    = r_sat_hi;
endmodule

// File: tb/tb_bgp_trim_sar_ctrl.sv
// tb_bgp_trim_sar_ctrl: directed bench with a comparator model against a linear bandgap LUT
// and a scoreboard of expected trial codes and committed results.
module tb_bgp_trim_sar_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, abort, man_en, comp;
    logic [4:0] man_code;
    logic [4:0] trim, result;
    logic       busy, done, sat_lo, sat_hi;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct packed {
        logic [4:0] res;
        logic       lo;
        logic       hi;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] cq[$];

    bgp_trim_sar_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_manual_en(man_en), .i_manual_code(man_code), .i_comp_in(comp),
        .o_trim_code(trim), .o_busy(busy), .o_done(done), .o_result(result),
        .o_sat_lo(sat_lo), .o_sat_hi(sat_hi)
    );

    always #5 clk = ~clk;

    // TT bandgap: VREF in mV as a function of trim code
    function automatic int lut(input logic [4:0] c);
        return 418 + 5 * int'(c);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_trim(input int tgt);
        logic [4:0] c, t;
        c = 5'd0;
        for (int b = 4; b >= 0; b--) begin
            t = c | (5'd1 << b);
            cq.push_back(t);
            if (lut(t) <= tgt) c = t;
        end
        sb.push_back({c, c == 5'd0, c == 5'd31});
    endtask

    task automatic run_trim(input int tgt, input bit noisy, input string tag);
        bit   seen;
        exp_t e;
        expect_trim(tgt);
        start = 1'b1;
        tick;
        start = 1'b0;
        seen  = 1'b0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            comp = (lut(trim) > tgt) ^ (noisy && (cyc % 8 == 6));
            if (cyc == 1) check({tag, "_busy_start"}, busy, 1);
            if (cyc % 8 == 1 && cyc <= 33) begin
                if (cq.size() > 0) check({tag, "_code"}, trim, cq.pop_front());
                else check({tag, "_code_underflow"}, 0, 1);
            end
            if (done) begin
                seen = 1'b1;
                check({tag, "_done_cycle"}, cyc, 41);
                tick;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({tag, "_result"}, result, e.res);
                    check({tag, "_sat_lo"}, sat_lo, e.lo);
                    check({tag, "_sat_hi"}, sat_hi, e.hi);
                    check({tag, "_trim_after"}, trim, e.res);
                end else check({tag, "_sb_underflow"}, 0, 1);
                check({tag, "_busy_after"}, busy, 0);
                check({tag, "_done_pulse"}, done, 0);
            end else tick;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; man_en = 1'b0; man_code = 5'd0; comp = 1'b0;
        tick;
        tick;
        check("rst_trim", trim, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", {sat_lo, sat_hi}, 0);
        rst = 1'b0;
        tick;

        run_trim(500, 1'b0, "t500");

        // abort during SETTLE of bit 2
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i < 18; i++) begin
            comp = lut(trim) > 500;
            tick;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_trim", trim, 16);
        check("abort_result", result, 16);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            seen |= done | busy;
            tick;
        end
        check("abort_quiet", seen, 0);
        cq.delete();
        sb.delete();

        run_trim(700, 1'b0, "t700");
        run_trim(400, 1'b0, "t400");
        run_trim(500, 1'b1, "t500_noisy");

        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);

        man_en = 1'b1;
        man_code = 5'd21;
        tick;
        check("manual_trim", trim, 21);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("manual_start_busy", busy, 0);
        tick;
        check("manual_busy_hold", busy, 0);
        check("manual_trim_hold", trim, 21);
        man_en = 1'b0;
        tick;
        check("manual_release_trim", trim, 16);

        // reset in the middle of SAMPLE of the first bit
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            comp = lut(trim) > 700;
            tick;
        end
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_trim", trim, 0);
        check("midrst_result", result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sat", {sat_lo, sat_hi}, 0);
        cq.delete();
        sb.delete();
        tick;
        run_trim(500, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
